fsrc_seq_trig_gen: RTL and testbench

Parametrised trigger and GPIO timing engine for the FSRC sequencer. It runs a per-period counter in the `clk` domain and drives NUM_TRIG trigger outputs, each independently in window or pulse mode. It also drives a CTRL_WIDTH-bit GPIO word, and supports an external-trigger arm, a repeat count and configuration latched at start. It sits directly behind the sequencer register map, whose already-synchronised control fields feed its inputs.

---
 rtl/fsrc_seq_trig_gen.sv | 200 ++++++++++++++++++++
 tb/tb_fsrc_seq_trig_gen.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fsrc_seq_trig_gen.sv
// fsrc_seq_trig_gen
// Trigger and GPIO timing engine for the FSRC sequencer. A per-period
// counter runs in RUN and drives NUM_TRIG trigger channels (window or pulse
// mode) plus a GPIO word that is applied at a programmable count. Runs are
// started by a seq_start rising edge. A run can optionally be armed and then
// released by an ext_trig rising edge. It repeats for a programmed number of
// periods, or forever when the repeat count is zero.
module fsrc_seq_trig_gen #(
  parameter int NUM_TRIG      = 4,
  parameter int COUNTER_WIDTH = 16,
  parameter int CTRL_WIDTH    = 40
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              seq_en,
  input  logic                              seq_start,
  input  logic                              ext_trig_en,
  input  logic                              ext_trig,
  input  logic [COUNTER_WIDTH-1:0]          period_cnt,
  input  logic [15:0]                       repeat_cnt,
  input  logic [NUM_TRIG*COUNTER_WIDTH-1:0] first_trig_cnt,
  input  logic [NUM_TRIG*COUNTER_WIDTH-1:0] second_trig_cnt,
  input  logic [NUM_TRIG-1:0]               trig_mode,
  input  logic [CTRL_WIDTH-1:0]             gpio_w,
  input  logic [COUNTER_WIDTH-1:0]          gpio_change_cnt,
  output logic [NUM_TRIG-1:0]               trig_out,
  output logic [CTRL_WIDTH-1:0]             gpio_out,
  output logic                              busy,
  output logic                              done,
  output logic [15:0]                       period_idx
);

  localparam logic [COUNTER_WIDTH-1:0] CNT_ONE = COUNTER_WIDTH'(1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_RUN
  } state_t;

  state_t                   state;
  logic [COUNTER_WIDTH-1:0] cnt;

  // Edge detection: sample stage plus previous-sample stage per input.
  logic edge_vld;
  logic start_q;
  logic start_qq;
  logic ext_q;
  logic ext_qq;
  logic start_rise;
  logic ext_rise;

  // Configuration captured when a run is accepted.
  logic [COUNTER_WIDTH-1:0] cfg_period;
  logic [15:0]              cfg_repeat;
  logic [COUNTER_WIDTH-1:0] cfg_first  [NUM_TRIG];
  logic [COUNTER_WIDTH-1:0] cfg_second [NUM_TRIG];
  logic [NUM_TRIG-1:0]      cfg_mode;
  logic [CTRL_WIDTH-1:0]    cfg_gpio_w;
  logic [COUNTER_WIDTH-1:0] cfg_gpio_cnt;

  logic                start_go;
  logic                cnt_last;
  logic                run_final;
  logic [NUM_TRIG-1:0] trig_nxt;

  // Rising-edge detectors for seq_start and ext_trig. The first sample after
  // reset seeds both stages, so a level already high at that point does not
  // count as an edge.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    if (reset) begin
      edge_vld <= 1'b0;
      start_q  <= 1'b0;
      start_qq <= 1'b0;
      ext_q    <= 1'b0;
      ext_qq   <= 1'b0;
    end else begin
      edge_vld <= 1'b1;
      start_q  <= seq_start;
      ext_q    <= ext_trig;
      start_qq <= edge_vld ? start_q : seq_start;
      ext_qq   <= edge_vld ? ext_q   : ext_trig;
    end
  end

  assign start_rise = start_q & ~start_qq;
  assign ext_rise   = ext_q   & ~ext_qq;

  // A start is taken only from IDLE, while enabled, and with a nonzero period.
  assign start_go  = (state == ST_IDLE) && seq_en && start_rise &&
                     (period_cnt != '0);
  assign cnt_last  = (cnt == (cfg_period - CNT_ONE));
  assign run_final = (cfg_repeat != 16'd0) &&
                     ((period_idx + 16'd1) == cfg_repeat);

  // Capture the run configuration on an accepted start.
  always_ff @(posedge clk) begin
    // NOTE: these holding registers are deliberately left without reset; they
    // are only read in ARMED/RUN, which can only be entered through a load.
    if (start_go) begin
      cfg_period   <= period_cnt;
      cfg_repeat   <= repeat_cnt;
      cfg_mode     <= trig_mode;
      cfg_gpio_w   <= gpio_w;
      cfg_gpio_cnt <= gpio_change_cnt;
      for (int i = 0; i < NUM_TRIG; i++) begin
        cfg_first[i]  <= first_trig_cnt[i*COUNTER_WIDTH +: COUNTER_WIDTH];
        cfg_second[i] <= second_trig_cnt[i*COUNTER_WIDTH +: COUNTER_WIDTH];
      end
    end
  end

  // Per-channel trigger decision for the current count. Window mode is high
  // on [first, second); because cnt never exceeds P-1, a first >= P never
  // fires and a second > P is clipped at the wrap. Pulse mode fires on either
  // match, and equal counts collapse to one pulse.
  always_comb begin
    // NOTE: default every bit first so no path leaves trig_nxt unassigned,
    // which would otherwise infer a latch.
    trig_nxt = '0;
    for (int i = 0; i < NUM_TRIG; i++) begin
      if (cfg_mode[i]) begin
        trig_nxt[i] = (cnt == cfg_first[i]) || (cnt == cfg_second[i]);
      end else begin
        trig_nxt[i] = (cnt >= cfg_first[i]) && (cnt < cfg_second[i]);
      end
    end
  end

  // Sequencer FSM with registered outputs. seq_en low overrides everything
  // except reset. trig_out lags cnt by one clock, so the decision made at
  // cnt = P-1 is still visible in the first IDLE cycle after completion.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      trig_out   <= '0;
      gpio_out   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      period_idx <= 16'd0;
    end else if (!seq_en) begin
      // Abort: no done pulse; gpio_out and period_idx hold.
      state    <= ST_IDLE;
      cnt      <= '0;
      trig_out <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          trig_out <= '0;
          if (start_go) begin
            state      <= ext_trig_en ? ST_ARMED : ST_RUN;
            cnt        <= '0;
            busy       <= 1'b1;
            period_idx <= 16'd0;
          end
        end

        ST_ARMED: begin
          trig_out <= '0;
          if (ext_rise) begin
            state <= ST_RUN;
            cnt   <= '0;
          end
        end

        ST_RUN: begin
          trig_out <= trig_nxt;
          if (cnt == cfg_gpio_cnt) begin
            gpio_out <= cfg_gpio_w;
          end
          if (cnt_last) begin
            cnt        <= '0;
            period_idx <= period_idx + 16'd1;
            if (run_final) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        default: begin
          state    <= ST_IDLE;
          cnt      <= '0;
          trig_out <= '0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fsrc_seq_trig_gen.sv
// Testbench for fsrc_seq_trig_gen: directed scenarios with literal
// expectations, plus a cycle-level behavioural model compared every cycle.
module tb_fsrc_seq_trig_gen;

  localparam int NT = 4;
  localparam int CW = 16;
  localparam int GW = 40;

  logic              clk = 1'b0;
  logic              reset;
  logic              seq_en;
  logic              seq_start;
  logic              ext_trig_en;
  logic              ext_trig;
  logic [CW-1:0]     period_cnt;
  logic [15:0]       repeat_cnt;
  logic [NT*CW-1:0]  first_trig_cnt;
  logic [NT*CW-1:0]  second_trig_cnt;
  logic [NT-1:0]     trig_mode;
  logic [GW-1:0]     gpio_w;
  logic [CW-1:0]     gpio_change_cnt;
  logic [NT-1:0]     trig_out;
  logic [GW-1:0]     gpio_out;
  logic              busy;
  logic              done;
  logic [15:0]       period_idx;

  logic [CW-1:0]     f_cnt [NT];
  logic [CW-1:0]     s_cnt [NT];

  int checks = 0;
  int errors = 0;

  localparam logic [GW-1:0] GPIO_A5 = 40'hA5A5A5A5A5;

  fsrc_seq_trig_gen #(
    .NUM_TRIG      (NT),
    .COUNTER_WIDTH (CW),
    .CTRL_WIDTH    (GW)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .seq_en          (seq_en),
    .seq_start       (seq_start),
    .ext_trig_en     (ext_trig_en),
    .ext_trig        (ext_trig),
    .period_cnt      (period_cnt),
    .repeat_cnt      (repeat_cnt),
    .first_trig_cnt  (first_trig_cnt),
    .second_trig_cnt (second_trig_cnt),
    .trig_mode       (trig_mode),
    .gpio_w          (gpio_w),
    .gpio_change_cnt (gpio_change_cnt),
    .trig_out        (trig_out),
    .gpio_out        (gpio_out),
    .busy            (busy),
    .done            (done),
    .period_idx      (period_idx)
  );

  always #5 clk = ~clk;

  always_comb begin
    first_trig_cnt  = '0;
    second_trig_cnt = '0;
    for (int i = 0; i < NT; i++) begin
      first_trig_cnt[i*CW +: CW]  = f_cnt[i];
      second_trig_cnt[i*CW +: CW] = s_cnt[i];
    end
  end

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_ch(input int ch, input int f, input int s);
    f_cnt[ch] = CW'(f);
    s_cnt[ch] = CW'(s);
  endtask

  // ---------------------------------------------------------------------
  // Behavioural model. A run is tracked as elapsed clocks in RUN; the count
  // is elapsed mod P and completed periods are elapsed / P. Edges are taken
  // from the previous two post-reset samples of each input.
  // ---------------------------------------------------------------------
  int            m_phase;      // 0 idle, 1 armed, 2 running
  int            m_elapsed;
  int            m_nsmp;
  logic          s1, s2, x1, x2;
  int            m_p, m_rep, m_g;
  int            m_f [NT];
  int            m_s [NT];
  logic [NT-1:0] m_mode;
  logic [GW-1:0] m_gw;
  bit            m_ok = 1'b0;
  logic [NT-1:0] e_trig;
  logic [GW-1:0] e_gpio;
  logic          e_busy, e_done;
  logic [15:0]   e_pidx;

  always @(posedge clk) begin : model
    bit rs;
    bit rx;
    int k;
    if (reset) begin
      m_phase = 0; m_elapsed = 0; m_nsmp = 0;
      s1 = 1'b0; s2 = 1'b0; x1 = 1'b0; x2 = 1'b0;
      e_trig = '0; e_gpio = '0; e_busy = 1'b0; e_done = 1'b0; e_pidx = '0;
      m_ok = 1'b1;
    end else begin
      rs = (m_nsmp >= 2) && s1 && !s2;
      rx = (m_nsmp >= 2) && x1 && !x2;
      s2 = s1; s1 = seq_start;
      x2 = x1; x1 = ext_trig;
      if (m_nsmp < 2) m_nsmp++;
      e_done = 1'b0;
      if (!seq_en) begin
        m_phase = 0; e_trig = '0; e_busy = 1'b0;
      end else if (m_phase == 0) begin
        e_trig = '0;
        if (rs && period_cnt != 0) begin
          m_p = int'(period_cnt); m_rep = int'(repeat_cnt); m_g = int'(gpio_change_cnt);
          m_mode = trig_mode; m_gw = gpio_w;
          for (int i = 0; i < NT; i++) begin
            m_f[i] = int'(f_cnt[i]); m_s[i] = int'(s_cnt[i]);
          end
          e_pidx = '0; m_elapsed = 0; e_busy = 1'b1;
          m_phase = ext_trig_en ? 1 : 2;
        end
      end else if (m_phase == 1) begin
        e_trig = '0;
        if (rx) begin m_phase = 2; m_elapsed = 0; end
      end else begin
        k = m_elapsed % m_p;
        for (int i = 0; i < NT; i++) begin
          if (m_mode[i]) e_trig[i] = (k == m_f[i]) || (k == m_s[i]);
          else           e_trig[i] = (k >= m_f[i]) && (k < m_s[i]);
        end
        if (k == m_g) e_gpio = m_gw;
        if (k == m_p - 1) begin
          e_pidx = 16'((m_elapsed / m_p) + 1);
          if (m_rep != 0 && int'(e_pidx) == m_rep) begin
            m_phase = 0; e_busy = 1'b0; e_done = 1'b1;
          end
        end
        m_elapsed++;
      end
    end
  end

  // Every-cycle comparison of the DUT against the model, away from posedge.
  always @(negedge clk) begin
    if (m_ok) begin
      check("mdl_trig", 64'(trig_out),   64'(e_trig));
      check("mdl_gpio", 64'(gpio_out),   64'(e_gpio));
      check("mdl_busy", 64'(busy),       64'(e_busy));
      check("mdl_done", 64'(done),       64'(e_done));
      check("mdl_pidx", 64'(period_idx), 64'(e_pidx));
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; seq_en = 1'b0; seq_start = 1'b0;
    ext_trig_en = 1'b0; ext_trig = 1'b0;
    period_cnt = 16'd10; repeat_cnt = 16'd1; trig_mode = '0;
    gpio_w = '0; gpio_change_cnt = 16'd100;
    for (int i = 0; i < NT; i++) set_ch(i, 0, 0);
    tick(3);

    // Reset values.
    check("rst_trig", 64'(trig_out), 64'(0));
    check("rst_gpio", 64'(gpio_out), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_pidx", 64'(period_idx), 64'(0));

    // seq_start already high at reset release is not an edge.
    seq_en = 1'b1; seq_start = 1'b1;
    tick(1);
    reset = 1'b0;
    tick(6);
    check("lvl_start_busy", 64'(busy), 64'(0));
    seq_start = 1'b0;
    tick(3);

    // Basic window: P=10, repeat=2, ch0 [2,5), plus degenerate channels.
    period_cnt = 16'd10; repeat_cnt = 16'd2; trig_mode = 4'b0000;
    set_ch(0, 2, 5); set_ch(1, 5, 5); set_ch(2, 8, 20); set_ch(3, 12, 15);
    seq_start = 1'b1;
    for (int i = 0; i <= 22; i++) begin
      tick(1);
      if (i == 2) seq_start = 1'b0;
      check("win_trig0", 64'(trig_out[0]), 64'((i >= 4 && i <= 6) || (i >= 14 && i <= 16)));
      check("win_done",  64'(done), 64'(i == 21));
      check("win_busy",  64'(busy), 64'(i >= 1 && i <= 20));
    end
    check("win_pidx", 64'(period_idx), 64'(2));

    // Pulse mode: ch1 3/7, ch2 4/4, ch3 9/0 with P=8; ch0 full window.
    period_cnt = 16'd8; repeat_cnt = 16'd1; trig_mode = 4'b1110;
    set_ch(0, 0, 8); set_ch(1, 3, 7); set_ch(2, 4, 4); set_ch(3, 9, 0);
    seq_start = 1'b1;
    for (int i = 0; i <= 11; i++) begin
      tick(1);
      if (i == 2) seq_start = 1'b0;
      check("pls_trig0", 64'(trig_out[0]), 64'(i >= 2 && i <= 9));
      check("pls_trig1", 64'(trig_out[1]), 64'(i == 5 || i == 9));
      check("pls_trig2", 64'(trig_out[2]), 64'(i == 6));
      check("pls_done",  64'(done), 64'(i == 9));
    end

    // External arm: wait 20+ clocks armed, then release.
    period_cnt = 16'd6; repeat_cnt = 16'd1; trig_mode = 4'b0000;
    set_ch(0, 0, 3); set_ch(1, 0, 0); set_ch(2, 0, 0); set_ch(3, 0, 0);
    ext_trig_en = 1'b1;
    seq_start = 1'b1;
    for (int i = 0; i <= 21; i++) begin
      tick(1);
      if (i == 2) seq_start = 1'b0;
      check("arm_busy", 64'(busy), 64'(i >= 1));
      check("arm_trig", 64'(trig_out), 64'(0));
    end
    ext_trig = 1'b1;
    for (int j = 0; j <= 8; j++) begin
      tick(1);
      if (j == 1) ext_trig = 1'b0;
      check("ext_trig0", 64'(trig_out[0]), 64'(j >= 2 && j <= 4));
      check("ext_busy",  64'(busy), 64'(j <= 6));
      check("ext_done",  64'(done), 64'(j == 7));
    end
    ext_trig_en = 1'b0;

    // GPIO update and config latching: P=16, repeat=2, change at cnt 6.
    period_cnt = 16'd16; repeat_cnt = 16'd2;
    set_ch(0, 2, 5);
    gpio_w = GPIO_A5; gpio_change_cnt = 16'd6;
    seq_start = 1'b1;
    for (int i = 0; i <= 34; i++) begin
      tick(1);
      if (i == 1) seq_start = 1'b0;
      if (i == 3) begin
        set_ch(0, 0, 5); gpio_w = 40'h1234; gpio_change_cnt = 16'd1;
      end
      check("gp_gpio",  64'(gpio_out), 64'((i >= 8) ? GPIO_A5 : 40'h0));
      check("gp_trig0", 64'(trig_out[0]), 64'((i >= 4 && i <= 6) || (i >= 20 && i <= 22)));
      check("gp_done",  64'(done), 64'(i == 33));
    end
    gpio_w = '0; gpio_change_cnt = 16'd100;

    // Abort mid-period: trig clears, no done, gpio holds.
    period_cnt = 16'd10; repeat_cnt = 16'd0;
    set_ch(0, 0, 10);
    seq_start = 1'b1;
    for (int i = 0; i <= 5; i++) begin
      tick(1);
      if (i == 1) seq_start = 1'b0;
    end
    check("abt_trig_pre", 64'(trig_out[0]), 64'(1));
    seq_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check("abt_busy", 64'(busy), 64'(0));
      check("abt_trig", 64'(trig_out), 64'(0));
      check("abt_done", 64'(done), 64'(0));
      check("abt_gpio", 64'(gpio_out), 64'(GPIO_A5));
    end
    seq_en = 1'b1;
    tick(2);

    // Start with period 0 is ignored.
    period_cnt = 16'd0;
    seq_start = 1'b1;
    for (int i = 0; i <= 5; i++) begin
      tick(1);
      check("p0_busy", 64'(busy), 64'(0));
    end
    seq_start = 1'b0;
    tick(2);

    // Start while busy is ignored: completion time unchanged.
    period_cnt = 16'd10; repeat_cnt = 16'd1;
    set_ch(0, 2, 5);
    seq_start = 1'b1;
    for (int i = 0; i <= 13; i++) begin
      tick(1);
      if (i == 2) seq_start = 1'b0;
      if (i == 4) seq_start = 1'b1;
      if (i == 7) seq_start = 1'b0;
      check("bsy_done", 64'(done), 64'(i == 11));
      check("bsy_busy", 64'(busy), 64'(i >= 1 && i <= 10));
    end

    // Infinite run with P=4, then reset in the middle of a window.
    period_cnt = 16'd4; repeat_cnt = 16'd0;
    set_ch(0, 0, 3);
    seq_start = 1'b1;
    for (int i = 0; i <= 14; i++) begin
      tick(1);
      if (i == 1) seq_start = 1'b0;
      if (i >= 1) check("inf_pidx", 64'(period_idx), 64'((i - 1) / 4));
      check("inf_done", 64'(done), 64'(0));
    end
    check("inf_trig0", 64'(trig_out[0]), 64'(1));
    reset = 1'b1;
    tick(1);
    check("mrst_trig", 64'(trig_out), 64'(0));
    check("mrst_gpio", 64'(gpio_out), 64'(0));
    check("mrst_busy", 64'(busy), 64'(0));
    check("mrst_done", 64'(done), 64'(0));
    check("mrst_pidx", 64'(period_idx), 64'(0));
    reset = 1'b0;
    tick(4);
    check("post_rst_busy", 64'(busy), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
